// File: rtl/borrowselect_sub.sv
// Nibble-serial borrow-select subtractor: d = a - b - bin, one 4-bit nibble per CALC cycle.
// Define SUB_OVF_EN to add the signed-overflow output v.
module borrowselect_sub #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] d,
  output logic         bout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
`ifdef SUB_OVF_EN
  ,
  output logic         v
`endif
);

  // state | meaning
  // IDLE  | waiting for an operation, in_ready=1
  // CALC  | one nibble of the difference resolved per cycle, LSB nibble first
  // DONE  | result held on d/bout until out_ready

  localparam int NN = W / 4;
  localparam int KW = (NN > 1) ? $clog2(NN) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [W-1:0]  ar;
  logic [W-1:0]  br;
  logic [W-1:0]  dr;
  logic [KW-1:0] k;
  logic          brw;
  logic          bout_r;
  logic          accept;
  logic          step;
  logic          last;
  logic [3:0]    a_nib;
  logic [3:0]    b_nib;
  logic [4:0]    diff0;
  logic [4:0]    diff1;
  logic [3:0]    sel_nib;
  logic          sel_brw;

  // Both candidates are formed every cycle; the registered borrow only picks one.
  always_comb begin
    a_nib   = ar[{k, 2'b00} +: 4];
    b_nib   = br[{k, 2'b00} +: 4];
    diff0   = {1'b0, a_nib} - {1'b0, b_nib};
    diff1   = diff0 - 5'd1;
    sel_nib = brw ? diff1[3:0] : diff0[3:0];
    sel_brw = brw ? diff1[4] : diff0[4];
    last    = (k == KW'(NN - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          accept   = 1'b1;
          state_nx = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

`ifdef SUB_OVF_EN
  logic v_r;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ar     <= '0;
      br     <= '0;
      dr     <= '0;
      k      <= '0;
      brw    <= 1'b0;
      bout_r <= 1'b0;
`ifdef SUB_OVF_EN
      v_r    <= 1'b0;
`endif
    end else if (accept) begin
      ar  <= a;
      br  <= b;
      k   <= '0;
      brw <= bin;
    end else if (step) begin
      dr[{k, 2'b00} +: 4] <= sel_nib;
      brw                 <= sel_brw;
      if (last) begin
        bout_r <= sel_brw;
`ifdef SUB_OVF_EN
        // sel_nib[3] is the final d[W-1]
        v_r    <= (ar[W-1] ^ br[W-1]) & (sel_nib[3] ^ ar[W-1]);
`endif
      end else begin
        k <= k + KW'(1);
      end
    end
  end

  assign d    = dr;
  assign bout = bout_r;
`ifdef SUB_OVF_EN
  assign v    = v_r;
`endif

endmodule

// File: tb/tb_borrowselect_sub.sv
// Directed bench for borrowselect_sub at W=16: vectors, DONE hold, mid-op reset, back-to-back.
module tb_borrowselect_sub;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] d;
  logic         bout;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         busy;
`ifdef SUB_OVF_EN
  logic         v;
`endif

  borrowselect_sub #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .bout      (bout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef SUB_OVF_EN
    ,
    .v         (v)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         v;
  } vec_t;

  vec_t vecs[7];
  vec_t ops[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input vec_t t);
    int lat;
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    a = t.a; b = t.b; bin = t.bin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd4);
    chk({tag, "_d"}, 32'(d), 32'(t.d));
    chk({tag, "_bout"}, 32'(bout), 32'(t.bo));
`ifdef SUB_OVF_EN
    chk({tag, "_v"}, 32'(v), 32'(t.v));
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_ovdrop"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int pulses;
    int n_acc;
    int n_res;
    int acc_cyc[4];
    logic rdy_s;

    vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b1};
    vecs[3] = '{16'hA5A5, 16'hA5A5, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[4] = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[5] = '{16'h1000, 16'h0001, 1'b1, 16'h0FFE, 1'b0, 1'b0};
    vecs[6] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};

    ops[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    ops[1] = '{16'hFFFF, 16'h0001, 1'b1, 16'hFFFD, 1'b0, 1'b0};
    ops[2] = '{16'h0010, 16'h0020, 1'b0, 16'hFFF0, 1'b1, 1'b0};
    ops[3] = '{16'hABCD, 16'hABCD, 1'b1, 16'hFFFF, 1'b1, 1'b0};

    // reset state
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd1);
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i]);
    end

    // DONE hold with out_ready low; in_valid pulses with other operands must be ignored
    a = 16'h5555; b = 16'h1111; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("hold_lat", 32'(lat), 32'd4);
    a = 16'hFFFF; b = 16'h0001; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("hold%0d_d", i), 32'(d), 32'h4444);
      chk($sformatf("hold%0d_bout", i), 32'(bout), 32'd0);
      chk($sformatf("hold%0d_ov", i), 32'(out_valid), 32'd1);
      chk($sformatf("hold%0d_rdy", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("hold_rel_rdy", 32'(in_ready), 32'd1);
    chk("hold_rel_ov", 32'(out_valid), 32'd0);

    // reset while k=2
    a = 16'h9876; b = 16'h1234; bin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_ov", 32'(out_valid), 32'd0);
    chk("mrst_d", 32'(d), 32'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) pulses++;
    end
    chk("mrst_nopulse", 32'(pulses), 32'd0);

    // back-to-back with in_valid and out_ready held high, operands scrambled during CALC
    n_acc = 0;
    n_res = 0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      rdy_s = in_ready;
      if (in_ready && n_acc < 4) begin
        a = ops[n_acc].a; b = ops[n_acc].b; bin = ops[n_acc].bin;
      end else begin
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      end
      tick();
      if (rdy_s && n_acc < 4) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      if (out_valid && n_res < 4) begin
        chk($sformatf("b2b%0d_d", n_res), 32'(d), 32'(ops[n_res].d));
        chk($sformatf("b2b%0d_bout", n_res), 32'(bout), 32'(ops[n_res].bo));
        n_res++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_nacc", 32'(n_acc), 32'd4);
    chk("b2b_nres", 32'(n_res), 32'd4);
    for (int i = 0; i < 3; i++) begin
      if (i + 1 < n_acc) begin
        chk($sformatf("b2b_gap%0d", i), 32'(acc_cyc[i+1] - acc_cyc[i]), 32'(W / 4 + 2));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
